// File: rtl/alu_dispatcher_if.sv
// ============================================================================
//  Module      : alu_dispatcher_pkg / alu_dispatcher_if
//  Description : Packet types and the bundled requester/ALU/response bus
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_dispatcher_pkg;
   typedef enum logic [2:0] {
      NOP      = 3'd0,
      ADD      = 3'd1,
      SUB      = 3'd2,
      MULTIPLY = 3'd3,
      AND      = 3'd4,
      OR       = 3'd5,
      XOR      = 3'd6
   } command_t;

   typedef enum logic [1:0] {
      NO_RESPONSE = 2'd0,
      SUCCESS     = 2'd1,
      OVERFLOW    = 2'd2,
      UNUSED      = 2'd3
   } response_t;

   typedef struct packed {
      command_t    command;
      logic [31:0] data1;
      logic [31:0] data2;
   } input_packet_t;

   typedef struct packed {
      response_t   response;
      logic [31:0] data;
   } output_packet_t;
endpackage

interface alu_dispatcher_if #(
   parameter int NUM_REQ = 4
);
   import alu_dispatcher_pkg::*;
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]          req_valid;
   logic [NUM_REQ-1:0]          req_ready;
   input_packet_t [NUM_REQ-1:0] req_packet;
   input_packet_t [3:0]         alu_in;
   output_packet_t [3:0]        alu_out;
   logic                        rsp_valid;
   logic                        rsp_ready;
   output_packet_t              rsp_packet;
   logic [ID_W-1:0]             rsp_req_id;
   logic [1:0]                  rsp_lane;
   logic [3:0]                  busy_lanes;
   logic [7:0]                  spurious_cnt;

   modport master (
      output req_valid, req_packet, alu_out, rsp_ready,
      input  req_ready, alu_in, rsp_valid, rsp_packet, rsp_req_id,
             rsp_lane, busy_lanes, spurious_cnt
   );

   modport slave (
      input  req_valid, req_packet, alu_out, rsp_ready,
      output req_ready, alu_in, rsp_valid, rsp_packet, rsp_req_id,
             rsp_lane, busy_lanes, spurious_cnt
   );
endinterface

`default_nettype wire

// File: rtl/alu_dispatcher.sv
// ============================================================================
//  Module      : alu_dispatcher
//  Description : Round-robin scheduler of requester commands onto 4 ALU lanes
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_dispatcher
   import alu_dispatcher_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int TIMEOUT_CYC = 16
) (
   input  wire logic          clk_i,
   input  wire logic          rst_i,
   alu_dispatcher_if.slave    bus
);

   localparam int ID_W = $clog2(NUM_REQ);
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      LS_FREE   = 2'd0,
      LS_ISSUED = 2'd1,
      LS_DONE   = 2'd2
   } lane_state_e;

   lane_state_e         lane_q     [4];
   logic [ID_W-1:0]     lane_id_q  [4];
   logic [WD_W-1:0]     lane_wd_q  [4];
   output_packet_t      lane_rsp_q [4];
   input_packet_t [3:0] alu_in_q;
   logic [ID_W-1:0]     req_ptr_q;
   logic [1:0]          rsp_ptr_q;
   logic                hold_q;
   logic [1:0]          hold_lane_q;
   logic [7:0]          spur_q;
   logic [7:0]          spur_d;

   logic                win_found;
   logic [ID_W-1:0]     win_id;
   logic                win_nop;
   logic                free_found;
   logic [1:0]          free_lane;
   logic                grant;
   logic                rsp_any;
   logic [1:0]          rsp_first;
   logic [1:0]          sel_lane;
   logic                rsp_hs;
   logic [2:0]          spur_n;
   logic [8:0]          spur_sum;

   // Requester scan: indices at/after the pointer first, then wrap to the low ones
   always_comb begin
      win_found  = 1'b0;
      win_id     = '0;
      free_found = 1'b0;
      free_lane  = 2'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!win_found && bus.req_valid[i] && (ID_W'(i) >= req_ptr_q)) begin
            win_found = 1'b1;
            win_id    = ID_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!win_found && bus.req_valid[i]) begin
            win_found = 1'b1;
            win_id    = ID_W'(i);
         end
      end
      for (int l = 3; l >= 0; l--) begin
         if (lane_q[l] == LS_FREE) begin
            free_found = 1'b1;
            free_lane  = 2'(l);
         end
      end
      win_nop = (bus.req_packet[win_id].command == NOP);
      grant   = !rst_i && win_found && (win_nop || free_found);
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req_ready[i] = grant && (win_id == ID_W'(i));
      end
   end

   // Once a response is presented without ready, the chosen lane is pinned
   always_comb begin
      rsp_any   = 1'b0;
      rsp_first = 2'd0;
      for (int l = 0; l < 4; l++) begin
         if (!rsp_any && lane_q[l] == LS_DONE && (2'(l) >= rsp_ptr_q)) begin
            rsp_any   = 1'b1;
            rsp_first = 2'(l);
         end
      end
      for (int l = 0; l < 4; l++) begin
         if (!rsp_any && lane_q[l] == LS_DONE) begin
            rsp_any   = 1'b1;
            rsp_first = 2'(l);
         end
      end
      sel_lane = hold_q ? hold_lane_q : rsp_first;
      rsp_hs   = rsp_any && bus.rsp_ready;

      spur_n = 3'd0;
      for (int l = 0; l < 4; l++) begin
         spur_n = spur_n + {2'b00, (bus.alu_out[l].response != NO_RESPONSE) &&
                                   (lane_q[l] != LS_ISSUED)};
      end
      spur_sum = {1'b0, spur_q} + {6'd0, spur_n};
      spur_d   = spur_sum[8] ? 8'hFF : spur_sum[7:0];
   end

   assign bus.rsp_valid    = rsp_any;
   assign bus.rsp_packet   = rsp_any ? lane_rsp_q[sel_lane] : '0;
   assign bus.rsp_req_id   = rsp_any ? lane_id_q[sel_lane] : '0;
   assign bus.rsp_lane     = rsp_any ? sel_lane : 2'd0;
   assign bus.alu_in       = alu_in_q;
   assign bus.spurious_cnt = spur_q;

   for (genvar g = 0; g < 4; g++) begin : g_busy
      assign bus.busy_lanes[g] = (lane_q[g] != LS_FREE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int l = 0; l < 4; l++) begin
            lane_q[l]     <= LS_FREE;
            lane_id_q[l]  <= '0;
            lane_wd_q[l]  <= '0;
            lane_rsp_q[l] <= '0;
         end
         alu_in_q    <= '0;
         req_ptr_q   <= '0;
         rsp_ptr_q   <= 2'd0;
         hold_q      <= 1'b0;
         hold_lane_q <= 2'd0;
         spur_q      <= 8'd0;
      end else begin
         alu_in_q <= '0;
         if (grant && !win_nop) begin
            alu_in_q[free_lane] <= bus.req_packet[win_id];
         end
         if (grant) begin
            req_ptr_q <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
         end
         for (int l = 0; l < 4; l++) begin
            unique case (lane_q[l])
               LS_FREE: begin
                  if (grant && !win_nop && free_lane == 2'(l)) begin
                     lane_q[l]    <= LS_ISSUED;
                     lane_id_q[l] <= win_id;
                     lane_wd_q[l] <= '0;
                  end
               end
               LS_ISSUED: begin
                  // A real response beats the watchdog when both land together
                  if (bus.alu_out[l].response != NO_RESPONSE) begin
                     lane_q[l]     <= LS_DONE;
                     lane_rsp_q[l] <= bus.alu_out[l];
                  end else if (lane_wd_q[l] == WD_LAST) begin
                     lane_q[l]     <= LS_DONE;
                     lane_rsp_q[l] <= '{response: UNUSED, data: 32'd0};
                  end else begin
                     lane_wd_q[l] <= lane_wd_q[l] + 1'b1;
                  end
               end
               LS_DONE: begin
                  if (rsp_hs && sel_lane == 2'(l)) begin
                     lane_q[l] <= LS_FREE;
                  end
               end
               default: lane_q[l] <= LS_FREE;
            endcase
         end
         if (rsp_hs) begin
            rsp_ptr_q <= sel_lane + 2'd1;
         end
         hold_q      <= rsp_any && !bus.rsp_ready;
         hold_lane_q <= sel_lane;
         spur_q      <= spur_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_dispatcher.sv
// ============================================================================
//  Module      : tb_alu_dispatcher
//  Description : Directed bench for alu_dispatcher with a stub 4-lane ALU
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_dispatcher;
   import alu_dispatcher_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   alu_dispatcher_if #(.NUM_REQ(4)) bus ();

   alu_dispatcher #(.NUM_REQ(4), .TIMEOUT_CYC(16)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   // Stub ALU: lane l answers 3+l cycles after it sees a command
   logic [2:0]     st_cnt [4];
   output_packet_t st_res [4];
   logic [3:0]     mute;
   logic [3:0]     inj;
   output_packet_t inj_pkt;

   function automatic output_packet_t alu_model(input input_packet_t p);
      output_packet_t r;
      logic [63:0]    w;
      w = 64'd0;
      r = '{response: SUCCESS, data: 32'd0};
      case (p.command)
         ADD:      w = {32'd0, p.data1} + {32'd0, p.data2};
         SUB:      w = {32'd0, p.data1 - p.data2};
         MULTIPLY: w = {32'd0, p.data1} * {32'd0, p.data2};
         AND:      w = {32'd0, p.data1 & p.data2};
         OR:       w = {32'd0, p.data1 | p.data2};
         XOR:      w = {32'd0, p.data1 ^ p.data2};
         default:  r.response = UNUSED;
      endcase
      if (w[63:32] != 32'd0) r.response = OVERFLOW;
      else                   r.data     = w[31:0];
      return r;
   endfunction

   always @(posedge clk) begin
      for (int l = 0; l < 4; l++) begin
         if (rst) begin
            st_cnt[l] <= 3'd0;
         end else if (bus.alu_in[l].command != NOP) begin
            st_cnt[l] <= 3'(3 + l);
            st_res[l] <= alu_model(bus.alu_in[l]);
         end else if (st_cnt[l] != 3'd0) begin
            st_cnt[l] <= st_cnt[l] - 3'd1;
         end
      end
   end

   always_comb begin
      bus.alu_out = '0;
      for (int l = 0; l < 4; l++) begin
         if (inj[l])                             bus.alu_out[l] = inj_pkt;
         else if (st_cnt[l] == 3'd1 && !mute[l]) bus.alu_out[l] = st_res[l];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.req_valid = '0;
      bus.rsp_ready = 1'b0;
      inj           = '0;
      mute          = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Present a command and hold it until accepted; returns one cycle after accept
   task automatic issue(input logic [1:0] r, input command_t c,
                        input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      bus.req_packet[r] = '{command: c, data1: a, data2: b};
      bus.req_valid[r]  = 1'b1;
      #1;
      while (!bus.req_ready[r] && n < 50) begin
         tick();
         #1;
         n++;
      end
      if (!bus.req_ready[r]) begin
         checks++; errors++;
         $display("FAIL issue_accept req%0d ready=%b required 1", r, bus.req_ready[r]);
      end
      tick();
      bus.req_valid[r] = 1'b0;
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      bus.rsp_ready = 1'b0;
      inj           = '0;
      mute          = '0;
      for (int r = 0; r < 4; r++) bus.req_packet[r] = '{command: ADD, data1: 32'd1, data2: 32'd2};
      bus.req_valid = 4'hF;
      tick();
      tick();
      checks++;
      if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b0 || bus.busy_lanes !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl ready=%b rsp_valid=%b busy=%b required 0000/0/0000",
                  bus.req_ready, bus.rsp_valid, bus.busy_lanes);
      end
      checks++;
      if (bus.alu_in !== '0 || bus.rsp_packet !== '0 || bus.spurious_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_data alu_in=%h rsp=%h spur=%0d required all zero",
                  bus.alu_in, bus.rsp_packet, bus.spurious_cnt);
      end
      bus.req_valid = '0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      int n;
      input_packet_t  ein;
      output_packet_t eout;
      do_reset();
      ein = '{command: ADD, data1: 32'd5, data2: 32'd7};
      bus.req_packet[0] = ein;
      bus.req_valid[0]  = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 4'b0001) begin
         errors++; $display("FAIL single_ready got=%b required 0001", bus.req_ready);
      end
      tick();
      bus.req_valid[0] = 1'b0;
      n = 1;
      checks++;
      if (bus.alu_in[0] !== ein || bus.alu_in[1].command !== NOP || bus.busy_lanes !== 4'b0001) begin
         errors++;
         $display("FAIL single_issue alu_in0=%h busy=%b required %h/0001", bus.alu_in[0], bus.busy_lanes, ein);
      end
      tick();
      n = 2;
      checks++;
      if (bus.alu_in[0].command !== NOP) begin
         errors++; $display("FAIL single_one_cycle cmd=%0d required NOP", bus.alu_in[0].command);
      end
      while (!bus.rsp_valid && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (n < 5 || n > 8) begin
         errors++; $display("FAIL single_latency got=%0d required 5..8", n);
      end
      eout = '{response: SUCCESS, data: 32'd12};
      checks++;
      if (bus.rsp_packet !== eout || bus.rsp_req_id !== 2'd0 || bus.rsp_lane !== 2'd0) begin
         errors++;
         $display("FAIL single_rsp pkt=%h id=%0d lane=%0d required %h/0/0",
                  bus.rsp_packet, bus.rsp_req_id, bus.rsp_lane, eout);
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.busy_lanes !== 4'b0000) begin
         errors++;
         $display("FAIL single_drain rsp_valid=%b busy=%b required 0/0000", bus.rsp_valid, bus.busy_lanes);
      end
   endtask

   task automatic test_back_to_back();
      int   n;
      logic stall_bad;
      do_reset();
      for (int r = 0; r < 4; r++) bus.req_packet[r] = '{command: ADD, data1: 32'(100 + r), data2: 32'd1};
      bus.req_valid = 4'hF;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if (bus.req_ready !== 4'(1 << k)) begin
            errors++; $display("FAIL b2b_ready_%0d got=%b required %b", k, bus.req_ready, 4'(1 << k));
         end
         tick();
         bus.req_valid[k] = 1'b0;
         checks++;
         if (bus.alu_in[k].data1 !== 32'(100 + k)) begin
            errors++; $display("FAIL b2b_lane_%0d data1=%0d required %0d", k, bus.alu_in[k].data1, 100 + k);
         end
      end
      // NOP needs no lane, so it is accepted even with every lane occupied
      bus.req_packet[1] = '{command: NOP, data1: 32'd0, data2: 32'd0};
      bus.req_valid[1]  = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 4'b0010) begin
         errors++; $display("FAIL b2b_nop_ready got=%b required 0010", bus.req_ready);
      end
      tick();
      bus.req_valid[1] = 1'b0;
      checks++;
      if (bus.busy_lanes !== 4'b1111 || bus.alu_in !== '0) begin
         errors++; $display("FAIL b2b_nop_nolane busy=%b alu_in=%h required 1111/0", bus.busy_lanes, bus.alu_in);
      end
      bus.req_packet[0] = '{command: ADD, data1: 32'd200, data2: 32'd1};
      bus.req_valid[0]  = 1'b1;
      stall_bad = 1'b0;
      n = 0;
      #1;
      while (!bus.rsp_valid && n < 40) begin
         if (bus.req_ready !== 4'b0000) stall_bad = 1'b1;
         tick();
         #1;
         n++;
      end
      checks++;
      if (stall_bad || bus.req_ready !== 4'b0000 || bus.rsp_lane !== 2'd0) begin
         errors++;
         $display("FAIL b2b_stall bad=%b ready=%b lane=%0d required 0/0000/0", stall_bad, bus.req_ready, bus.rsp_lane);
      end
      bus.rsp_ready = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 4'b0000) begin
         errors++; $display("FAIL b2b_same_cycle got=%b required 0000", bus.req_ready);
      end
      tick();
      bus.rsp_ready = 1'b0;
      #1;
      checks++;
      if (bus.req_ready !== 4'b0001) begin
         errors++; $display("FAIL b2b_after_free got=%b required 0001", bus.req_ready);
      end
      tick();
      bus.req_valid[0] = 1'b0;
      checks++;
      if (bus.alu_in[0].data1 !== 32'd200) begin
         errors++; $display("FAIL b2b_fifth_lane data1=%0d required 200", bus.alu_in[0].data1);
      end
      bus.rsp_ready = 1'b1;
      n = 0;
      while (bus.busy_lanes !== 4'b0000 && n < 60) begin
         tick();
         n++;
      end
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_hold();
      int             n;
      output_packet_t e0;
      logic           hold_bad;
      do_reset();
      for (int k = 0; k < 4; k++) issue(2'(k), ADD, 32'(16 * k + 1), 32'(k));
      n = 0;
      while (!bus.rsp_valid && n < 40) begin
         tick();
         n++;
      end
      e0 = '{response: SUCCESS, data: 32'd1};
      hold_bad = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (bus.rsp_valid !== 1'b1 || bus.rsp_packet !== e0 || bus.rsp_lane !== 2'd0) hold_bad = 1'b1;
         tick();
      end
      checks++;
      if (hold_bad) begin
         errors++;
         $display("FAIL hold_stable valid=%b pkt=%h lane=%0d required 1/%h/0", bus.rsp_valid, bus.rsp_packet, bus.rsp_lane, e0);
      end
      bus.rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_lane !== 2'(k) || bus.rsp_req_id !== 2'(k) ||
             bus.rsp_packet.data !== 32'(17 * k + 1)) begin
            errors++;
            $display("FAIL hold_drain_%0d valid=%b lane=%0d id=%0d data=%0d required 1/%0d/%0d/%0d",
                     k, bus.rsp_valid, bus.rsp_lane, bus.rsp_req_id, bus.rsp_packet.data, k, k, 17 * k + 1);
         end
         tick();
      end
      bus.rsp_ready = 1'b0;
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
         errors++; $display("FAIL hold_empty rsp_valid=%b required 0", bus.rsp_valid);
      end
   endtask

   task automatic test_ops();
      int             n;
      output_packet_t e;
      do_reset();
      issue(2'd0, MULTIPLY, 32'h0001_0000, 32'h0001_0000);
      n = 0;
      while (!bus.rsp_valid && n < 40) begin tick(); n++; end
      e = '{response: OVERFLOW, data: 32'd0};
      checks++;
      if (bus.rsp_packet !== e) begin
         errors++; $display("FAIL ops_mul_overflow got=%h required %h", bus.rsp_packet, e);
      end
      bus.rsp_ready = 1'b1; tick(); bus.rsp_ready = 1'b0;
      issue(2'd2, AND, 32'h0000_F0F0, 32'h0000_FF00);
      n = 0;
      while (!bus.rsp_valid && n < 40) begin tick(); n++; end
      e = '{response: SUCCESS, data: 32'h0000_F000};
      checks++;
      if (bus.rsp_packet !== e || bus.rsp_req_id !== 2'd2 || bus.rsp_lane !== 2'd0) begin
         errors++;
         $display("FAIL ops_and pkt=%h id=%0d lane=%0d required %h/2/0", bus.rsp_packet, bus.rsp_req_id, bus.rsp_lane, e);
      end
      bus.rsp_ready = 1'b1; tick(); bus.rsp_ready = 1'b0;
   endtask

   task automatic test_spurious();
      logic seen;
      do_reset();
      inj_pkt = '{response: SUCCESS, data: 32'h55};
      inj = 4'b0010; tick(); inj = '0;
      checks++;
      if (bus.spurious_cnt !== 8'd1 || bus.rsp_valid !== 1'b0 || bus.busy_lanes !== 4'b0000) begin
         errors++;
         $display("FAIL spur_one cnt=%0d rsp_valid=%b busy=%b required 1/0/0000", bus.spurious_cnt, bus.rsp_valid, bus.busy_lanes);
      end
      inj = 4'b1101; tick(); inj = '0;
      checks++;
      if (bus.spurious_cnt !== 8'd4) begin
         errors++; $display("FAIL spur_multi cnt=%0d required 4", bus.spurious_cnt);
      end
      inj = 4'b1111;
      repeat (63) tick();
      inj = '0;
      checks++;
      if (bus.spurious_cnt !== 8'd255) begin
         errors++; $display("FAIL spur_saturate cnt=%0d required 255", bus.spurious_cnt);
      end
      inj = 4'b1111; tick(); inj = '0;
      checks++;
      if (bus.spurious_cnt !== 8'd255) begin
         errors++; $display("FAIL spur_hold cnt=%0d required 255", bus.spurious_cnt);
      end
      issue(2'd0, ADD, 32'd1, 32'd1);
      tick();
      rst = 1'b1; tick(); rst = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (bus.rsp_valid !== 1'b0) seen = 1'b1;
         tick();
      end
      checks++;
      if (seen || bus.busy_lanes !== 4'b0000 || bus.spurious_cnt !== 8'd0) begin
         errors++;
         $display("FAIL spur_reset_inflight rsp_seen=%b busy=%b cnt=%0d required 0/0000/0", seen, bus.busy_lanes, bus.spurious_cnt);
      end
   endtask

   task automatic test_timeout();
      int             n;
      output_packet_t e;
      do_reset();
      mute = 4'b0001;
      issue(2'd0, ADD, 32'd3, 32'd4);
      n = 1;
      while (!bus.rsp_valid && n < 40) begin tick(); n++; end
      // ISSUED during the 16 cycles after accept, DONE visible on the 17th
      checks++;
      if (n !== 17) begin
         errors++; $display("FAIL timeout_latency got=%0d required 17", n);
      end
      e = '{response: UNUSED, data: 32'd0};
      checks++;
      if (bus.rsp_packet !== e || bus.rsp_lane !== 2'd0 || bus.rsp_req_id !== 2'd0) begin
         errors++;
         $display("FAIL timeout_rsp pkt=%h lane=%0d id=%0d required %h/0/0", bus.rsp_packet, bus.rsp_lane, bus.rsp_req_id, e);
      end
      bus.rsp_ready = 1'b1; tick(); bus.rsp_ready = 1'b0;
      mute = '0;
      inj_pkt = '{response: SUCCESS, data: 32'd7};
      inj = 4'b0001; tick(); inj = '0;
      checks++;
      if (bus.spurious_cnt !== 8'd1 || bus.rsp_valid !== 1'b0) begin
         errors++; $display("FAIL timeout_late cnt=%0d rsp_valid=%b required 1/0", bus.spurious_cnt, bus.rsp_valid);
      end
   endtask

   initial begin
      bus.req_valid  = '0;
      bus.req_packet = '0;
      bus.rsp_ready  = 1'b0;
      inj            = '0;
      inj_pkt        = '0;
      mute           = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_hold();
      test_ops();
      test_spurious();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
